// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock sequencer producing pll_rst, sys_reset and ready from a synchronized lock flag
module pll_lock_sequencer #(
    parameter int PULSE_CYCLES   = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] retry_count,
    output logic [7:0] loss_count
);
    localparam int MAX_AB     = (PULSE_CYCLES > STABLE_CYCLES) ? PULSE_CYCLES : STABLE_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PLLRST = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      retry_q, retry_d;
    logic [7:0]      loss_q, loss_d;
    logic            sync1_q, locked_s_q;
    logic            pll_rst_q, sys_reset_q, ready_q;

    // locked is asynchronous to refclk; only the second flop feeds the state machine
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= locked;
            locked_s_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            ST_PLLRST: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // a lock arriving on the timeout cycle wins over the re-pulse
                if (locked_s_q) begin
                    state_d = ST_SETTLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_PLLRST;
                    if (retry_q != 8'hFF) begin
                        retry_d = retry_q + 8'd1;
                    end
                end
            end
            ST_SETTLE: begin
                if (!locked_s_q) begin
                    state_d = ST_WAIT;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!locked_s_q) begin
                    state_d = ST_PLLRST;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_PLLRST;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Outputs decode the next state so they flip on the same edge as the state
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PLLRST;
            cnt_q       <= '0;
            retry_q     <= 8'd0;
            loss_q      <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= (state_d == ST_PLLRST);
            sys_reset_q <= (state_d != ST_RUN);
            ready_q     <= (state_d == ST_RUN);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset   = sys_reset_q;
    assign ready       = ready_q;
    assign retry_count = retry_q;
    assign loss_count  = loss_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - randomized self-checking bench for pll_lock_sequencer against a countdown model
module tb_pll_lock_sequencer;
    localparam int P = 4;
    localparam int S = 20;
    localparam int T = 40;

    localparam int M_PULSE  = 0;
    localparam int M_WAIT   = 1;
    localparam int M_SETTLE = 2;
    localparam int M_RUN    = 3;

    logic       refclk = 1'b0;
    logic       rst;
    logic       locked;
    logic       pll_rst, sys_reset, ready;
    logic [7:0] retry_count, loss_count;
    logic [18:0] dut_vec;

    int n_run  = 0;
    int n_fail = 0;
    int edge_n = 0;

    int   m_mode, m_left, m_retry, m_loss;
    logic m_s1, m_s2;

    pll_lock_sequencer #(
        .PULSE_CYCLES  (P),
        .STABLE_CYCLES (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .locked     (locked),
        .pll_rst    (pll_rst),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .retry_count(retry_count),
        .loss_count (loss_count)
    );

    always #5 refclk = ~refclk;

    assign dut_vec = {pll_rst, sys_reset, ready, retry_count, loss_count};

    function automatic logic [18:0] model_vec();
        return {(m_mode == M_PULSE), (m_mode != M_RUN), (m_mode == M_RUN), 8'(m_retry), 8'(m_loss)};
    endfunction

    task automatic model_reset();
        m_mode  = M_PULSE;
        m_left  = P;
        m_retry = 0;
        m_loss  = 0;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
    endtask

    // the lock level acted on at an edge is the one sampled two edges earlier
    task automatic model_step(input logic l);
        logic ls;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = l;
        case (m_mode)
            M_PULSE: begin
                m_left--;
                if (m_left == 0) begin m_mode = M_WAIT; m_left = T; end
            end
            M_WAIT: begin
                if (ls) begin
                    m_mode = M_SETTLE; m_left = S;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = M_PULSE; m_left = P;
                        if (m_retry < 255) m_retry++;
                    end
                end
            end
            M_SETTLE: begin
                if (!ls) begin
                    m_mode = M_WAIT; m_left = T;
                end else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_RUN;
                end
            end
            default: begin
                if (!ls) begin
                    m_mode = M_PULSE; m_left = P;
                    if (m_loss < 255) m_loss++;
                end
            end
        endcase
    endtask

    task automatic tick(input logic l);
        locked = l;
        @(posedge refclk);
        edge_n++;
        model_step(l);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        repeat (3) @(posedge refclk);
        #1;
        rst    = 1'b0;
        edge_n = 0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        locked = 1'b1;
        #1;
        model_reset();
        n_run++;
        if (dut_vec !== {1'b1, 1'b1, 1'b0, 8'd0, 8'd0}) begin
            n_fail++; $display("FAIL reset_async: got %h need %h", dut_vec, {1'b1, 1'b1, 1'b0, 8'd0, 8'd0});
        end
        repeat (4) @(posedge refclk);
        #1;
        n_run++;
        if (dut_vec !== {1'b1, 1'b1, 1'b0, 8'd0, 8'd0}) begin
            n_fail++; $display("FAIL reset_held: got %h need %h", dut_vec, {1'b1, 1'b1, 1'b0, 8'd0, 8'd0});
        end
        locked = 1'b0;
    endtask

    task automatic test_power_up();
        int pulse_n, first_edge, ready_edge, guard;
        do_reset();
        pulse_n = int'(pll_rst);
        repeat (30) begin
            tick(1'b0);
            pulse_n += int'(pll_rst);
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL power_up edge %0d: dut %h model %h", edge_n, dut_vec, model_vec());
            end
        end
        n_run++;
        if (pulse_n !== P) begin
            n_fail++; $display("FAIL power_up_pulse_len: got %0d need %0d", pulse_n, P);
        end
        first_edge = edge_n + 1;
        ready_edge = -1;
        guard      = 0;
        while (!ready && guard < 200) begin
            tick(1'b1);
            guard++;
            if (ready) ready_edge = edge_n;
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL power_up edge %0d: dut %h model %h", edge_n, dut_vec, model_vec());
            end
        end
        n_run++;
        if (ready_edge !== first_edge + 2 + S) begin
            n_fail++; $display("FAIL power_up_ready_edge: got %0d need %0d", ready_edge, first_edge + 2 + S);
        end
    endtask

    task automatic test_timeout();
        int   rises;
        logic prev;
        do_reset();
        rises = 0;
        prev  = pll_rst;
        repeat (3 * (P + T) + 2) begin
            tick(1'b0);
            if (pll_rst && !prev) rises++;
            prev = pll_rst;
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL timeout edge %0d: dut %h model %h", edge_n, dut_vec, model_vec());
            end
        end
        n_run++;
        if (retry_count !== 8'd3 || rises !== 3) begin
            n_fail++; $display("FAIL timeout_retry3: got retry %0d pulses %0d need 3 and 3", retry_count, rises);
        end
    endtask

    task automatic test_saturation();
        repeat (300 * (P + T)) begin
            tick(1'b0);
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL saturation edge %0d: dut %h model %h", edge_n, dut_vec, model_vec());
            end
        end
        n_run++;
        if (retry_count !== 8'd255) begin
            n_fail++; $display("FAIL retry_saturate: got %0d need 255", retry_count);
        end
    endtask

    task automatic test_loss_in_run();
        int drop_edge, fall_edge, guard, pulse_n;
        do_reset();
        guard = 0;
        while (!ready && guard < 200) begin
            tick(1'b1);
            guard++;
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL loss_run edge %0d: dut %h model %h", edge_n, dut_vec, model_vec());
            end
        end
        repeat (5) tick(1'b1);
        drop_edge = edge_n + 1;
        fall_edge = -1;
        guard     = 0;
        while (ready && guard < 20) begin
            tick(1'b0);
            guard++;
            if (!ready) fall_edge = edge_n;
        end
        n_run++;
        if (fall_edge !== drop_edge + 2 || sys_reset !== 1'b1) begin
            n_fail++; $display("FAIL loss_fall_edge: got edge %0d sys_reset %b need %0d and 1", fall_edge, sys_reset, drop_edge + 2);
        end
        pulse_n = int'(pll_rst);
        repeat (P + 5) begin
            tick(1'b0);
            pulse_n += int'(pll_rst);
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL loss_run edge %0d: dut %h model %h", edge_n, dut_vec, model_vec());
            end
        end
        n_run++;
        if (pulse_n !== P || loss_count !== 8'd1) begin
            n_fail++; $display("FAIL loss_pulse: got pulse %0d loss %0d need %0d and 1", pulse_n, loss_count, P);
        end
    endtask

    task automatic test_settle_glitch();
        int   rise2, ready_edge, guard;
        logic saw_pulse;
        do_reset();
        repeat (P + 3) tick(1'b0);
        saw_pulse = 1'b0;
        repeat (10) begin tick(1'b1); saw_pulse |= pll_rst; end
        tick(1'b0);
        saw_pulse |= pll_rst;
        rise2      = edge_n + 1;
        ready_edge = -1;
        guard      = 0;
        while (!ready && guard < 200) begin
            tick(1'b1);
            guard++;
            saw_pulse |= pll_rst;
            if (ready) ready_edge = edge_n;
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL glitch edge %0d: dut %h model %h", edge_n, dut_vec, model_vec());
            end
        end
        n_run++;
        if (ready_edge !== rise2 + 2 + S || saw_pulse !== 1'b0) begin
            n_fail++; $display("FAIL glitch_ready: got edge %0d pulse %b need %0d and 0", ready_edge, saw_pulse, rise2 + 2 + S);
        end
    endtask

    task automatic test_simultaneous();
        int   ready_edge, guard;
        logic saw_pulse;
        do_reset();
        while (edge_n < P + T - 3) tick(1'b0);
        saw_pulse  = 1'b0;
        ready_edge = -1;
        guard      = 0;
        while (!ready && guard < 200) begin
            tick(1'b1);
            guard++;
            saw_pulse |= pll_rst;
            if (ready) ready_edge = edge_n;
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL simult edge %0d: dut %h model %h", edge_n, dut_vec, model_vec());
            end
        end
        n_run++;
        if (saw_pulse !== 1'b0 || retry_count !== 8'd0 || ready_edge !== P + T + S) begin
            n_fail++; $display("FAIL simult_priority: got pulse %b retry %0d ready %0d need 0 0 %0d", saw_pulse, retry_count, ready_edge, P + T + S);
        end
    endtask

    task automatic test_random();
        logic lv;
        int   len;
        do_reset();
        for (int s = 0; s < 40; s++) begin
            lv  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, S + 15);
            repeat (len) begin
                tick(lv);
                n_run++;
                if (dut_vec !== model_vec()) begin
                    n_fail++; $display("FAIL random edge %0d: dut %h model %h", edge_n, dut_vec, model_vec());
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int pulse_n, ready_edge, guard;
        do_reset();
        repeat (P + T + 1) tick(1'b0);
        repeat (3 + S / 2) tick(1'b1);
        #2;
        rst = 1'b1;
        #1;
        n_run++;
        if (dut_vec !== {1'b1, 1'b1, 1'b0, 8'd0, 8'd0}) begin
            n_fail++; $display("FAIL mid_reset_async: got %h need %h", dut_vec, {1'b1, 1'b1, 1'b0, 8'd0, 8'd0});
        end
        model_reset();
        repeat (2) @(posedge refclk);
        #1;
        rst        = 1'b0;
        edge_n     = 0;
        pulse_n    = int'(pll_rst);
        ready_edge = -1;
        guard      = 0;
        while (!ready && guard < 200) begin
            tick(1'b1);
            guard++;
            pulse_n += int'(pll_rst);
            if (ready) ready_edge = edge_n;
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL mid_reset edge %0d: dut %h model %h", edge_n, dut_vec, model_vec());
            end
        end
        n_run++;
        if (pulse_n !== P || ready_edge !== P + 1 + S) begin
            n_fail++; $display("FAIL mid_reset_restart: got pulse %0d ready %0d need %0d and %0d", pulse_n, ready_edge, P, P + 1 + S);
        end
    endtask

    initial begin
        rst    = 1'b1;
        locked = 1'b0;
        test_reset();
        test_power_up();
        test_timeout();
        test_saturation();
        test_loss_in_run();
        test_settle_glitch();
        test_simultaneous();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
